// File: rtl/dm_pkg.sv
// Shared defaults, FSM state type and counter limit for the data-memory responder.
package dm_pkg;
    localparam int DEF_AW = 8;
    localparam int DEF_DW = 8;
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } dm_state_t;
endpackage

// File: rtl/dm_sat_counter.sv
// 16-bit event counter with synchronous clear that sticks at CNT_MAX instead of wrapping.
module dm_sat_counter
    import dm_pkg::*;
(
    input  logic        clk,
    input  logic        clr,
    input  logic        en,
    output logic [15:0] count
);

    always_ff @(posedge clk) begin
        if (clr) begin
            count <= 16'd0;
        end else if (en && (count != CNT_MAX)) begin
            count <= count + 16'd1;
        end
    end

endmodule

// File: rtl/dat_mem_responder.sv
// Single-port data memory serving load/store requests with one-cycle registered response,
// a post-reset zero-fill sweep and saturating access counters.
module dat_mem_responder
    import dm_pkg::*;
#(
    parameter int AW             = DEF_AW,
    parameter int DW             = DEF_DW,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic          wr_en,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] dat_in,
    output logic [DW-1:0] dat_out,
    output logic          ack,
    output logic          busy,
    output logic [15:0]   rd_count,
    output logic [15:0]   wr_count
);

    localparam int DEPTH = 1 << AW;
    localparam logic [0:0] ST_CLEAR = CLEAR;
    localparam logic [0:0] ST_READY = READY;
    localparam logic [0:0] ST_RESET = CLEAR_ON_RESET ? ST_CLEAR : ST_READY;

    logic [DW-1:0] mem [DEPTH];
    logic [0:0]    state;
    logic [AW-1:0] ptr;
    logic          acc_p0;
    logic          mem_we;
    logic [AW-1:0] mem_wa;
    logic [DW-1:0] mem_wd;

    // A request arriving together with reset is dropped.
    assign acc_p0 = req && !reset && (state == ST_READY);
    assign busy   = (state == ST_CLEAR);

    // Sweep and store share the single write port; the FSM guarantees they never overlap.
    always_comb begin
        mem_we = 1'b0;
        mem_wa = ptr;
        mem_wd = '0;
        if (!reset) begin
            if (state == ST_CLEAR) begin
                mem_we = 1'b1;
            end else if (acc_p0 && wr_en) begin
                mem_we = 1'b1;
                mem_wa = addr;
                mem_wd = dat_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    // Stage p0 -> p1: registered response
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_RESET;
            ptr     <= '0;
            ack     <= 1'b0;
            dat_out <= '0;
        end else begin
            ack <= acc_p0;
            if (state == ST_CLEAR) begin
                ptr <= ptr + AW'(1);
                if (ptr == {AW{1'b1}}) begin
                    state <= ST_READY;
                end
            end
            if (acc_p0 && !wr_en) begin
                dat_out <= mem[addr];
            end
        end
    end

    dm_sat_counter u_rd_cnt (
        .clk   (clk),
        .clr   (reset),
        .en    (acc_p0 && !wr_en),
        .count (rd_count)
    );

    dm_sat_counter u_wr_cnt (
        .clk   (clk),
        .clr   (reset),
        .en    (acc_p0 && wr_en),
        .count (wr_count)
    );

endmodule

// File: doc/dat_mem_responder.md
# dat_mem_responder

Single-port 256×8 data-memory responder that serves load/store requests issued by the core's datapath or test sequencers. Each accepted request gets one-cycle registered read data and a one-cycle `ack`. After reset it runs a clear sweep so every location reads 0x00 before the first access. It also keeps saturating read and write access counters for milestone diagnostics.

## Interface
Parameters:
- `AW`, 8, address width; depth is 2**AW.
- `DW`, 8, data width.
- `CLEAR_ON_RESET`, 1, when 1 the memory is zero-filled after reset; when 0 contents are retained across reset.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  single system clock, all state on posedge.
- `reset`  in  1  synchronous, active-high.
- `req`  in  1  request valid, sampled on posedge.
- `wr_en`  in  1  with `req`: 1 = store, 0 = load.
- `addr`  in  AW  word address.
- `dat_in`  in  DW  store data.
- `dat_out`  out  DW  registered load data.
- `ack`  out  1  one-cycle pulse, request completed.
- `busy`  out  1  clear sweep in progress; requests ignored.
- `rd_count`  out  16  saturating count of completed loads.
- `wr_count`  out  16  saturating count of completed stores.

## Operation
- Reset values:
  - `dat_out` = 0x00, `ack` = 0, `rd_count` = 0, `wr_count` = 0.
  - `busy` = `CLEAR_ON_RESET`.
  - Clear pointer = 0.
- FSM states are CLEAR and READY.
  - On reset, the FSM enters CLEAR if `CLEAR_ON_RESET` = 1, otherwise READY.
- CLEAR:
  - Each cycle, write 0x00 to mem[ptr] and increment ptr.
  - When ptr = DEPTH-1 is written, go to READY. `busy` falls on that same edge.
  - `req` is ignored: no ack, no memory change, no counter change.
- READY, accepted request (`req` = 1 at posedge):
  - Store: mem[addr] ← `dat_in`; `ack` = 1 next cycle; `dat_out` unchanged; `wr_count` increments.
  - Load: `dat_out` ← mem[addr]; `ack` = 1 next cycle; `rd_count` increments.
- READY, no request (`req` = 0): `ack` = 0 next cycle and `dat_out` holds its last value.
- Back-to-back requests are accepted every cycle with no bubbles.
  - A load at edge n+1 to the address stored at edge n returns the new data.
- `wr_en` and `dat_in` are don't-care when `req` = 0.
- Counters saturate at 0xFFFF and do not wrap.
- The address is always in range: AW bits index exactly DEPTH words.
- Reset mid-operation (any state, including mid-sweep):
  - Applies all reset values above and restarts the sweep from address 0.
  - A request sampled in the same cycle as `reset` is dropped.

## Timing
- Load latency is 1 cycle: `req` sampled at edge n gives `dat_out` and `ack` valid after edge n, for one cycle.
- Store latency is 1 cycle to `ack`. The store is visible to a load sampled at edge n+1.
- Clear sweep, with `reset` low first sampled at edge E0:
  - Edges E0..E(DEPTH-1) write addresses 0..DEPTH-1.
  - `busy` = 0 after edge E(DEPTH-1).
  - The first request that can be accepted is sampled at E(DEPTH), i.e. 256 cycles for the default depth.
- No combinational path exists from any input to any output.

## Structure
- Package `dm_pkg` holds:
  - `AW`/`DW` defaults.
  - The `dm_state_t` enum {CLEAR, READY}.
  - The `CNT_MAX` = 16'hFFFF constant.
- Sub-module `dm_sat_counter` (16-bit, synchronous clear, enable, saturate at max) is instantiated twice, for `rd_count` and `wr_count`.
- Memory array, FSM and output registers live in `dat_mem_responder`.

## Test plan
- Reset, then idle: `busy` stays 1 for 256 cycles, then 0. Loads of addresses 0, 1, 255 then return 0x00 with one `ack` each.
- Store addr 0 = 0xA5 and addr 1 = 0x5A, then load both: returns 0xA5 and 0x5A. Store addr 2 = 0xFF (their XOR) and load it back as 0xFF. `wr_count` = 3, `rd_count` = 3.
- Back-to-back store addr 5 = 0x3C, then load addr 5 on the very next edge: `dat_out` = 0x3C, `ack` high two consecutive cycles.
- `req` held high with store addr 7 = 0x11 while `busy` = 1: no `ack`. After the sweep, addr 7 reads 0x00 and `wr_count` = 0.
- Assert `reset` at sweep cycle 100 after storing nothing: sweep restarts and `busy` lasts 256 cycles from release. With `CLEAR_ON_RESET` = 0, a value stored before reset (addr 9 = 0x77) still reads 0x77 after reset.
- Issue 65 540 loads: `rd_count` saturates at 0xFFFF and holds.
